// File: rtl/vit_pkg.sv
// Shared constants, types and helpers for the Viterbi decoder front end.
// Default symbol geometry is rate-1/2 with 16-bit packed input words.
package vit_pkg;

  localparam int SYM_W_DEF  = 2;
  localparam int WORD_W_DEF = 16;

  typedef logic [SYM_W_DEF-1:0] sym_t;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } ser_state_e;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/symbol_stream_buffer_fifo.sv
// Word FIFO with occupancy count, async reset and sync clear.
// Head entry is read combinationally so the serializer can load it on pop.
module sync_fifo
  import vit_pkg::*;
#(
  parameter int W     = WORD_W_DEF + 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= wdata;
  end

endmodule

// File: rtl/symbol_stream_buffer.sv
// Viterbi input stage: buffers packed code words and serializes them
// MSB-first into one code symbol per cycle with frame marking.
module symbol_stream_buffer
  import vit_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int SYM_W      = SYM_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_W-1:0]             in_word,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SYM_W-1:0]              out_sym,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int SYMS = WORD_W / SYM_W;
  localparam int IW   = (SYMS > 1) ? clog2(SYMS) : 1;

  if ((WORD_W % SYM_W) != 0) begin : g_bad_width
    $error("WORD_W must be a multiple of SYM_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  ser_state_e      state;
  ser_state_e      state_nxt;
  logic [WORD_W-1:0] shreg;
  logic            word_last;
  logic [IW-1:0]   idx;
  logic            at_end;
  logic            load;
  logic            consume;
  logic            push;
  logic            full;
  logic            empty;
  logic [WORD_W:0] head;

  assign at_end = (idx == IW'(SYMS - 1));
  assign push   = in_valid && !full && !flush;

  sync_fifo #(
    .W     (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (load),
    .wdata ({in_last, in_word}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

  // Serializer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next state, load and consume decisions; flush overrides everything.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    consume   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          load      = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (out_ready) begin
          consume = 1'b1;
          if (at_end) begin
            if (!empty)
              load = 1'b1;
            else
              state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
      load      = 1'b0;
      consume   = 1'b0;
    end
  end

  // Shift register and symbol index: load a fresh word or advance one symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      word_last <= 1'b0;
      idx       <= '0;
    end else if (flush) begin
      shreg     <= '0;
      word_last <= 1'b0;
      idx       <= '0;
    end else if (load) begin
      shreg     <= head[WORD_W-1:0];
      word_last <= head[WORD_W];
      idx       <= '0;
    end else if (consume && !at_end) begin
      shreg <= shreg << SYM_W;
      idx   <= idx + 1'b1;
    end
  end

  assign in_ready  = !full;
  assign out_valid = (state == S_SHIFT);
  assign out_sym   = out_valid ? shreg[WORD_W-1 -: SYM_W] : '0;
  assign out_last  = out_valid && word_last && at_end;

endmodule

// File: tb/tb_symbol_stream_buffer.sv
// Scoreboard bench for symbol_stream_buffer in two geometries:
// 16-bit words of 2-bit symbols, and 12-bit words of 3-bit symbols.
module tb_symbol_stream_buffer;

  logic        clk;
  logic        rst;

  logic        flush, in_valid, in_ready, in_last;
  logic        out_valid, out_ready, out_last;
  logic [15:0] in_word;
  logic [1:0]  out_sym;
  logic [2:0]  fill_level;

  logic        flush2, in_valid2, in_ready2, in_last2;
  logic        out_valid2, out_ready2, out_last2;
  logic [11:0] in_word2;
  logic [2:0]  out_sym2;
  logic [2:0]  fill_level2;

  int vectors;
  int miscompares;
  int pops;
  int nlast;
  int exp_q[$];
  int exp2_q[$];
  bit acc, acc2;
  bit s_ov, s_ir, s_ov2, s_ir2;
  logic [2:0] s_fl, s_fl2;
  logic [1:0] s_os;

  symbol_stream_buffer #(.WORD_W(16), .SYM_W(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_last(out_last),
    .fill_level(fill_level)
  );

  symbol_stream_buffer #(.WORD_W(12), .SYM_W(3), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_word(in_word2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sym(out_sym2), .out_last(out_last2),
    .fill_level(fill_level2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: sample at negedge, record accepted words, score symbols.
  task automatic tick();
    int e;
    int g;
    @(negedge clk);
    acc  = 1'b0;
    acc2 = 1'b0;
    s_ov = out_valid; s_ir = in_ready; s_fl = fill_level; s_os = out_sym;
    s_ov2 = out_valid2; s_ir2 = in_ready2; s_fl2 = fill_level2;
    if (!rst) begin
      if (in_valid && in_ready && !flush) begin
        acc = 1'b1;
        for (int i = 0; i < 8; i++)
          exp_q.push_back(((in_last && i == 7) ? 8 : 0) +
                          int'((in_word >> (14 - 2 * i)) & 16'h3));
      end
      if (in_valid2 && in_ready2 && !flush2) begin
        acc2 = 1'b1;
        for (int i = 0; i < 4; i++)
          exp2_q.push_back(((in_last2 && i == 3) ? 8 : 0) +
                           int'((in_word2 >> (9 - 3 * i)) & 12'h7));
      end
      if (out_valid && out_ready) begin
        vectors++;
        pops++;
        if (out_last) nlast++;
        g = (out_last ? 8 : 0) + int'(out_sym);
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_w16: got last*8+sym=%0d, required no output", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            miscompares++;
            $display("FAIL sb_w16: got last*8+sym=%0d, required %0d", g, e);
          end
        end
      end
      if (out_valid2 && out_ready2) begin
        vectors++;
        g = (out_last2 ? 8 : 0) + int'(out_sym2);
        if (exp2_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_w12: got last*8+sym=%0d, required no output", g);
        end else begin
          e = exp2_q.pop_front();
          if (g !== e) begin
            miscompares++;
            $display("FAIL sb_w12: got last*8+sym=%0d, required %0d", g, e);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int k = 0; k < budget && (exp_q.size() != 0 || exp2_q.size() != 0); k++)
      tick();
    vectors++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d/%0d symbols pending, required 0",
               name, exp_q.size(), exp2_q.size());
    end
  endtask

  task automatic test_reset();
    #8;
    vectors += 10;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_ov: got %b, required 0", out_valid); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ir: got %b, required 1", in_ready); end
    if (fill_level !== 3'd0) begin miscompares++; $display("FAIL rst_fl: got %0d, required 0", fill_level); end
    if (out_sym !== 2'd0) begin miscompares++; $display("FAIL rst_sym: got %0d, required 0", out_sym); end
    if (out_last !== 1'b0) begin miscompares++; $display("FAIL rst_last: got %b, required 0", out_last); end
    if (out_valid2 !== 1'b0) begin miscompares++; $display("FAIL rst_ov2: got %b, required 0", out_valid2); end
    if (in_ready2 !== 1'b1) begin miscompares++; $display("FAIL rst_ir2: got %b, required 1", in_ready2); end
    if (fill_level2 !== 3'd0) begin miscompares++; $display("FAIL rst_fl2: got %0d, required 0", fill_level2); end
    if (out_sym2 !== 3'd0) begin miscompares++; $display("FAIL rst_sym2: got %0d, required 0", out_sym2); end
    if (out_last2 !== 1'b0) begin miscompares++; $display("FAIL rst_last2: got %b, required 0", out_last2); end
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    in_word = 16'hB4E1; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (!acc) begin miscompares++; $display("FAIL single_acc: got 0, required 1"); end
    tick();
    vectors++;
    if (s_ov !== 1'b0) begin miscompares++; $display("FAIL single_lat1: got ov=%b, required 0", s_ov); end
    tick();
    vectors++;
    if (s_ov !== 1'b1) begin miscompares++; $display("FAIL single_lat2: got ov=%b, required 1", s_ov); end
    drain("single", 20);
  endtask

  task automatic test_back_to_back();
    int pushed = 0;
    int nvalid = 0;
    int bubbles = 0;
    int irlow = 0;
    bit seen = 0;
    out_ready = 1'b1;
    in_last = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (pushed < 8 && c % 7 == 0) begin
        in_word = 16'($urandom);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (acc) pushed++;
      if (!s_ir) irlow++;
      if (s_ov) begin
        seen = 1;
        nvalid++;
      end else if (seen && exp_q.size() != 0) begin
        bubbles++;
      end
      if (pushed == 8 && exp_q.size() == 0) break;
    end
    in_valid = 1'b0;
    vectors += 4;
    if (pushed != 8) begin miscompares++; $display("FAIL b2b_pushed: got %0d, required 8", pushed); end
    if (nvalid != 64) begin miscompares++; $display("FAIL b2b_valid: got %0d, required 64", nvalid); end
    if (bubbles != 0) begin miscompares++; $display("FAIL b2b_bubbles: got %0d, required 0", bubbles); end
    if (irlow != 0) begin miscompares++; $display("FAIL b2b_ready_low: got %0d, required 0", irlow); end
    drain("b2b", 10);
  endtask

  task automatic test_backpressure();
    int first;
    int p0;
    out_ready = 1'b0;
    in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_word = 16'($urandom); in_valid = 1'b1;
      tick();
      vectors++;
      if (!acc) begin miscompares++; $display("FAIL bp_push%0d: got not accepted, required accepted", i); end
    end
    first = exp_q[0];
    in_word = 16'hC3C3; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors += 5;
      if (acc) begin miscompares++; $display("FAIL bp_stall: got accepted, required stalled"); end
      if (s_ir !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %b, required 0", s_ir); end
      if (s_fl !== 3'd4) begin miscompares++; $display("FAIL bp_fill: got %0d, required 4", s_fl); end
      if (s_ov !== 1'b1) begin miscompares++; $display("FAIL bp_ov: got %b, required 1", s_ov); end
      if (int'(s_os) != (first & 3)) begin
        miscompares++; $display("FAIL bp_hold: got sym %0d, required %0d", s_os, first & 3);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    p0 = pops;
    drain("bp", 80);
    vectors++;
    if (pops - p0 != 40) begin miscompares++; $display("FAIL bp_count: got %0d, required 40", pops - p0); end
  endtask

  task automatic test_frame_last();
    int n0;
    out_ready = 1'b1;
    in_word = 16'h0003; in_last = 1'b1; in_valid = 1'b1;
    n0 = nlast;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    drain("last", 20);
    vectors++;
    if (nlast - n0 != 1) begin miscompares++; $display("FAIL last_count: got %0d, required 1", nlast - n0); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_word = 16'($urandom); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (s_fl !== 3'd2) begin miscompares++; $display("FAIL fl_pre: got %0d, required 2", s_fl); end
    out_ready = 1'b1;
    tick(); tick(); tick();
    flush = 1'b1; in_valid = 1'b1; in_word = 16'hFFFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors += 2;
      if (s_ov !== 1'b0) begin miscompares++; $display("FAIL fl_ov: got %b, required 0", s_ov); end
      if (s_fl !== 3'd0) begin miscompares++; $display("FAIL fl_fill: got %0d, required 0", s_fl); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_word = 16'($urandom); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    vectors += 5;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_ov: got %b, required 0", out_valid); end
    if (out_sym !== 2'd0) begin miscompares++; $display("FAIL rm_sym: got %0d, required 0", out_sym); end
    if (out_last !== 1'b0) begin miscompares++; $display("FAIL rm_last: got %b, required 0", out_last); end
    if (fill_level !== 3'd0) begin miscompares++; $display("FAIL rm_fill: got %0d, required 0", fill_level); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready: got %b, required 1", in_ready); end
    #3 rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    in_word = 16'h1E2D; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("rm", 20);
  endtask

  task automatic test_w12_single();
    out_ready2 = 1'b1;
    in_word2 = 12'hA5C; in_last2 = 1'b0; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    tick();
    vectors++;
    if (s_ov2 !== 1'b0) begin miscompares++; $display("FAIL w12_lat1: got ov=%b, required 0", s_ov2); end
    tick();
    vectors++;
    if (s_ov2 !== 1'b1) begin miscompares++; $display("FAIL w12_lat2: got ov=%b, required 1", s_ov2); end
    drain("w12_single", 20);
  endtask

  task automatic test_w12_back_to_back();
    int pushed = 0;
    int nvalid = 0;
    int bubbles = 0;
    int irlow = 0;
    bit seen = 0;
    out_ready2 = 1'b1;
    in_last2 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (pushed < 8 && c % 3 == 0) begin
        in_word2 = 12'($urandom);
        in_last2 = (pushed == 7);
        in_valid2 = 1'b1;
      end else begin
        in_valid2 = 1'b0;
      end
      tick();
      if (acc2) pushed++;
      if (!s_ir2) irlow++;
      if (s_ov2) begin
        seen = 1;
        nvalid++;
      end else if (seen && exp2_q.size() != 0) begin
        bubbles++;
      end
      if (pushed == 8 && exp2_q.size() == 0) break;
    end
    in_valid2 = 1'b0;
    in_last2 = 1'b0;
    vectors += 3;
    if (nvalid != 32) begin miscompares++; $display("FAIL w12_valid: got %0d, required 32", nvalid); end
    if (bubbles != 0) begin miscompares++; $display("FAIL w12_bubbles: got %0d, required 0", bubbles); end
    if (irlow != 0) begin miscompares++; $display("FAIL w12_ready_low: got %0d, required 0", irlow); end
    drain("w12_b2b", 10);
  endtask

  initial begin
    vectors = 0; miscompares = 0; pops = 0; nlast = 0;
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_word = '0; in_last = 1'b0; out_ready = 1'b1;
    flush2 = 1'b0; in_valid2 = 1'b0; in_word2 = '0; in_last2 = 1'b0; out_ready2 = 1'b1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_frame_last();
    test_flush();
    test_reset_mid();
    test_w12_single();
    test_w12_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
